// File: rtl/vj_ii_if.sv
// ---------------------------------------------------------------------------
// vj_ii_if -- bus bundle between the integral-image builder and its
// surroundings (frame control, pixel stream, integral-image RAM ports).
//
// Signals
//   start      frame build request                  (to builder)
//   busy       builder is clearing/streaming/writing (from builder)
//   done       one-cycle end-of-frame pulse          (from builder)
//   err        sticky framing error                  (from builder)
//   pix_valid / pix_ready / pix_data / pix_last      raster pixel stream
//   ram_we / ram_waddr / ram_wdata                   RAM write port
//   ram_raddr / ram_rdata                            RAM read port (1-cycle latency)
//   sq_rdata / sq_wdata   squared-integral RAM data, present only when
//                         VJ_II_SQ_EN is defined
//
// Modports
//   master  the builder side
//   slave   the environment side (pixel source, RAM, controller)
// ---------------------------------------------------------------------------
interface vj_ii_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int PIX_W  = 8
`ifdef VJ_II_SQ_EN
  ,
  parameter int SQ_W   = 34
`endif
);
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_last;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
`ifdef VJ_II_SQ_EN
  logic [SQ_W-1:0]   sq_rdata;
  logic [SQ_W-1:0]   sq_wdata;
`endif

  modport master (
    input  start, pix_valid, pix_data, pix_last, ram_rdata,
`ifdef VJ_II_SQ_EN
    input  sq_rdata,
    output sq_wdata,
`endif
    output busy, done, err, pix_ready, ram_we, ram_waddr, ram_wdata, ram_raddr
  );

  modport slave (
    output start, pix_valid, pix_data, pix_last, ram_rdata,
`ifdef VJ_II_SQ_EN
    output sq_rdata,
    input  sq_wdata,
`endif
    input  busy, done, err, pix_ready, ram_we, ram_waddr, ram_wdata, ram_raddr
  );
endinterface

// File: rtl/vj_ii_builder.sv
// ---------------------------------------------------------------------------
// vj_ii_builder -- builds the (IMG_W+1)x(IMG_H+1) integral image used by the
// Viola-Jones window evaluator.
//
// A start request first zeroes the padding row (row 0) and padding column
// (column 0), one RAM word per cycle. The builder then accepts a raster pixel
// stream at one pixel per clock: on each accept it reads the integral value one
// row above, and on the following cycle writes
//   ii[y+1][x+1] = ii[y][x+1] + (sum of row y up to and including x).
// After the last pixel's write it pulses done and returns to idle, leaving the
// RAM read port free for the evaluator.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   bus (vj_ii_if.master)
//     start             begin a build (only honoured while idle)
//     busy/done/err     status; err is sticky until rst or the next start
//     pix_*             valid/ready pixel stream, pix_last framing marker
//     ram_*             both ports of the integral-image RAM (1-cycle read)
//     sq_rdata/sq_wdata squared-integral RAM data (VJ_II_SQ_EN only)
//
// Optional feature macro: VJ_II_SQ_EN
//   When defined, a squared row sum of pix_data*pix_data is kept alongside
//   the plain row sum and written to a parallel RAM that shares the address
//   and write-enable lines of the main RAM.
// ---------------------------------------------------------------------------
module vj_ii_builder #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int PIX_W  = 8
`ifdef VJ_II_SQ_EN
  ,
  parameter int SQ_W   = 34
`endif
) (
  input  logic    clk,
  input  logic    rst,
  vj_ii_if.master bus
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(IMG_W + IMG_H + 1);

  localparam logic [ADDR_W-1:0] STRIDE       = ADDR_W'(IMG_W + 1);
  localparam logic [XW-1:0]     X_LAST       = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST       = YW'(IMG_H - 1);
  localparam logic [CW-1:0]     CLR_LAST     = CW'(IMG_W + IMG_H);
  localparam logic [CW-1:0]     CLR_ROW0_END = CW'(IMG_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  // Integral arithmetic wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  function automatic logic [DATA_W-1:0] pix_ext(input logic [PIX_W-1:0] p);
    return DATA_W'(p);
  endfunction

`ifdef VJ_II_SQ_EN
  function automatic logic [SQ_W-1:0] sq_add(input logic [SQ_W-1:0] a,
                                             input logic [SQ_W-1:0] b);
    return a + b;
  endfunction

  function automatic logic [SQ_W-1:0] pix_sq(input logic [PIX_W-1:0] p);
    logic [2*PIX_W-1:0] pe;
    logic [2*PIX_W-1:0] prod;
    pe   = (2*PIX_W)'(p);
    prod = pe * pe;
    return SQ_W'(prod);
  endfunction
`endif

  state_t            state_q,   state_d;
  logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [XW-1:0]     x_q,       x_d;
  logic [YW-1:0]     y_q,       y_d;
  // base = y*(IMG_W+1)+x for the next pixel, so the read address is base+1
  // and the write address is base+IMG_W+2; stepping it avoids any multiply.
  logic [ADDR_W-1:0] base_q,    base_d;
  logic [DATA_W-1:0] row_q,     row_d;
  logic [ADDR_W-1:0] raddr_q,   raddr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              pend_q,    pend_d;
  logic              err_q,     err_d;
  logic              done_q,    done_d;
`ifdef VJ_II_SQ_EN
  logic [SQ_W-1:0]   sq_row_q,  sq_row_d;
`endif

  logic              clearing;
  logic              is_final;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_addr_d = clr_addr_q;
    x_d        = x_q;
    y_d        = y_q;
    base_d     = base_q;
    row_d      = row_q;
    raddr_d    = raddr_q;
    wr_addr_d  = wr_addr_q;
    pend_d     = 1'b0;
    err_d      = err_q;
    done_d     = 1'b0;
`ifdef VJ_II_SQ_EN
    sq_row_d   = sq_row_q;
`endif
    is_final   = (x_q == X_LAST) && (y_q == Y_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_CLEAR;
          err_d      = 1'b0;
          clr_cnt_d  = '0;
          clr_addr_d = '0;
          x_d        = '0;
          y_d        = '0;
          base_d     = '0;
          row_d      = '0;
`ifdef VJ_II_SQ_EN
          sq_row_d   = '0;
`endif
        end
      end

      ST_CLEAR: begin
        // Row 0 is contiguous (step 1), and address IMG_W+1 (row 1, col 0)
        // directly follows it; from there column 0 steps by a full row.
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_STREAM;
        end else begin
          clr_cnt_d  = clr_cnt_q + CW'(1);
          clr_addr_d = clr_addr_q +
                       ((clr_cnt_q <= CLR_ROW0_END) ? ADDR_W'(1) : STRIDE);
        end
      end

      ST_STREAM: begin
        if (bus.pix_valid) begin
          pend_d    = 1'b1;
          raddr_d   = base_q + ADDR_W'(1);
          wr_addr_d = base_q + STRIDE + ADDR_W'(1);
          row_d     = (x_q == '0) ? pix_ext(bus.pix_data)
                                  : add_mod(row_q, pix_ext(bus.pix_data));
`ifdef VJ_II_SQ_EN
          sq_row_d  = (x_q == '0) ? pix_sq(bus.pix_data)
                                  : sq_add(sq_row_q, pix_sq(bus.pix_data));
`endif
          // Framing is only reported; the pixel count alone ends the frame.
          if (bus.pix_last != is_final) begin
            err_d = 1'b1;
          end
          if (x_q == X_LAST) begin
            x_d    = '0;
            y_d    = y_q + YW'(1);
            base_d = base_q + ADDR_W'(2);
          end else begin
            x_d    = x_q + XW'(1);
            base_d = base_q + ADDR_W'(1);
          end
          if (is_final) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        // The final pixel's write happens in this cycle via pend_q.
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---- accept stage -> write stage register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      clr_addr_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      base_q     <= '0;
      row_q      <= '0;
      raddr_q    <= '0;
      wr_addr_q  <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef VJ_II_SQ_EN
      sq_row_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_addr_q <= clr_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      base_q     <= base_d;
      row_q      <= row_d;
      raddr_q    <= raddr_d;
      wr_addr_q  <= wr_addr_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      done_q     <= done_d;
`ifdef VJ_II_SQ_EN
      sq_row_q   <= sq_row_d;
`endif
    end
  end

  // ---- write stage: row-above data arrives from the RAM this cycle ----
  assign clearing      = (state_q == ST_CLEAR);

  // The read address is presented in the accept cycle itself so the RAM's
  // one-cycle latency lines up with the write one cycle later.
  assign bus.ram_raddr = raddr_d;

  // rst also suppresses the write in the cycle it is asserted, dropping any
  // pending pixel write.
  assign bus.ram_we    = ~rst & (clearing | pend_q);
  assign bus.ram_waddr = clearing ? clr_addr_q : wr_addr_q;
  assign bus.ram_wdata = pend_q ? add_mod(bus.ram_rdata, row_q) : '0;
`ifdef VJ_II_SQ_EN
  assign bus.sq_wdata  = pend_q ? sq_add(bus.sq_rdata, sq_row_q) : '0;
`endif

  assign bus.pix_ready = (state_q == ST_STREAM);
  assign bus.busy      = clearing | (state_q == ST_STREAM) | pend_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_vj_ii_builder.sv
// ---------------------------------------------------------------------------
// tb_vj_ii_builder -- scoreboard bench for vj_ii_builder on a 4x3 image.
// Stimulus pushes the expected RAM writes (cycle, address, value) and done
// pulses into queues; a negedge monitor pops and compares them against what
// the builder drives. Expected integral values come from direct rectangle
// sums over the frame's pixels. A small RAM model closes the loop.
// ---------------------------------------------------------------------------
module tb_vj_ii_builder;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 8;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
    logic [33:0] sq;
  } wr_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   scrub;

  wr_t  exp_q[$];
  int   done_q[$];
  int unsigned pix_arr [0:N-1];

  logic [31:0] mem [0:255];
`ifdef VJ_II_SQ_EN
  logic [33:0] sq_mem [0:255];
  vj_ii_if #(.ADDR_W(AW), .DATA_W(32), .PIX_W(8), .SQ_W(34)) bus ();
`else
  vj_ii_if #(.ADDR_W(AW), .DATA_W(32), .PIX_W(8)) bus ();
`endif

  vj_ii_builder #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(32), .PIX_W(8)
`ifdef VJ_II_SQ_EN
    , .SQ_W(34)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 1-cycle read latency.
  always @(posedge clk) begin
    if (scrub) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD_BEEF;
    end else if (bus.ram_we) begin
      mem[bus.ram_waddr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_raddr];
  end
`ifdef VJ_II_SQ_EN
  always @(posedge clk) begin
    if (scrub) begin
      for (int i = 0; i < 256; i++) sq_mem[i] <= 34'h1_2345_6789;
    end else if (bus.ram_we) begin
      sq_mem[bus.ram_waddr] <= bus.sq_wdata;
    end
    bus.sq_rdata <= sq_mem[bus.ram_raddr];
  end
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_ii(input int r, input int c);
    logic [31:0] s;
    s = '0;
    for (int yy = 0; yy < r; yy++)
      for (int xx = 0; xx < c; xx++)
        s = s + 32'(pix_arr[yy*W+xx]);
    return s;
  endfunction

  function automatic logic [33:0] ref_sq(input int r, input int c);
    logic [33:0] s;
    s = '0;
    for (int yy = 0; yy < r; yy++)
      for (int xx = 0; xx < c; xx++)
        s = s + 34'(pix_arr[yy*W+xx] * pix_arr[yy*W+xx]);
    return s;
  endfunction

  // Monitor: compares every cycle's write port and done against the queues.
  always @(negedge clk) begin
    wr_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("wr_missed", 64'(exp_q[0].cyc), 64'(cyc));
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("wr_we", bus.ram_we, 1'b1);
      chk("wr_addr", bus.ram_waddr, 64'(e.addr));
      chk("wr_data", bus.ram_wdata, e.data);
`ifdef VJ_II_SQ_EN
      chk("wr_sq", bus.sq_wdata, e.sq);
`endif
    end else if (bus.ram_we) begin
      chk("wr_spurious", bus.ram_we, 1'b0);
    end
    if (done_q.size() > 0 && done_q[0] == cyc) begin
      void'(done_q.pop_front());
      chk("done_pulse", bus.done, 1'b1);
      chk("busy_at_done", bus.busy, 1'b0);
    end else if (bus.done) begin
      chk("done_spurious", bus.done, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_err"},   bus.err, 0);
    chk({tag, "_ready"}, bus.pix_ready, 0);
    chk({tag, "_we"},    bus.ram_we, 0);
    chk({tag, "_waddr"}, bus.ram_waddr, 0);
    chk({tag, "_wdata"}, bus.ram_wdata, 0);
    chk({tag, "_raddr"}, bus.ram_raddr, 0);
  endtask

  task automatic start_frame();
    int k;
    bit bad;
    chk("idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    k = cyc;
    for (int i = 0; i < W + 1 + H; i++)
      exp_q.push_back('{cyc: k + 1 + i, addr: (i <= W) ? i : (i - W) * (W + 1),
                        data: 32'd0, sq: 34'd0});
    tick();
    bus.start = 1'b0;
    chk("err_cleared", bus.err, 0);
    bad = 1'b0;
    for (int i = 0; i < W + 1 + H; i++) begin
      if (bus.pix_ready) bad = 1'b1;
      tick();
    end
    chk("clear_ready_low", bad, 0);
    chk("stream_ready", bus.pix_ready, 1);
  endtask

  task automatic send_pixel(input int idx, input bit last, input bit push);
    int x;
    int y;
    x = idx % W;
    y = idx / W;
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'(pix_arr[idx]);
    bus.pix_last  = last;
    #1;
    chk("pix_ready", bus.pix_ready, 1);
    chk("raddr", bus.ram_raddr, 64'(y * (W + 1) + x + 1));
    if (push) begin
      exp_q.push_back('{cyc: cyc + 1, addr: (y + 1) * (W + 1) + x + 1,
                        data: ref_ii(y + 1, x + 1), sq: ref_sq(y + 1, x + 1)});
      if (idx == N - 1) done_q.push_back(cyc + 2);
    end
    tick();
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input int extra_last, input bit final_last);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_pixel(i, (i == N - 1) ? final_last : (i == extra_last), 1'b1);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || done_q.size() != 0); i++) tick();
    chk("drain", 64'(exp_q.size() + done_q.size()), 0);
  endtask

  task automatic check_ram();
    for (int r = 0; r <= H; r++)
      for (int c = 0; c <= W; c++)
        chk($sformatf("ram[%0d][%0d]", r, c), mem[r*(W+1)+c], ref_ii(r, c));
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) pix_arr[i] = $urandom_range(0, 255);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    scrub = 1'b1;
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    bus.pix_last = 1'b0;
    repeat (3) tick();
    scrub = 1'b0;
    rst = 1'b0;
    #1;
    chk_idle_outputs("reset");

    // All-ones frame, back to back.
    start_frame();
    for (int i = 0; i < N; i++) pix_arr[i] = 1;
    send_frame(1'b0, -1, 1'b1);
    wait_drain();
    chk("ones_ii19", mem[19], 12);
    chk("ones_ii9", mem[9], 4);
    chk("ones_ii13", mem[13], 6);
    chk("ones_err", bus.err, 0);
    check_ram();

    // Pixels 1..12 with random gaps; start held high while busy is ignored.
    start_frame();
    for (int i = 0; i < N; i++) pix_arr[i] = i + 1;
    bus.start = 1'b1;
    send_frame(1'b1, -1, 1'b1);
    bus.start = 1'b0;
    wait_drain();
    chk("gaps_err", bus.err, 0);
    check_ram();

    // Early pix_last on pixel 5: sticky error, frame still completes.
    start_frame();
    fill_random();
    send_frame(1'b0, 5, 1'b1);
    wait_drain();
    chk("early_last_err", bus.err, 1);
    repeat (3) tick();
    chk("early_last_sticky", bus.err, 1);
    check_ram();

    // Missing pix_last on the final pixel; start clears the earlier error.
    start_frame();
    fill_random();
    send_frame(1'b1, -1, 1'b0);
    wait_drain();
    chk("missing_last_err", bus.err, 1);
    check_ram();

    // Reset during pixel 7: the pending write of pixel 6 is dropped.
    start_frame();
    fill_random();
    for (int i = 0; i < 6; i++) send_pixel(i, 1'b0, i < 5);
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'(pix_arr[6]);
    rst = 1'b1;
    tick();
    chk_idle_outputs("midrst");
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    scrub = 1'b1;
    tick();
    scrub = 1'b0;
    chk("midrst_drain", 64'(exp_q.size()), 0);

    // Full rebuild over a scrubbed RAM.
    start_frame();
    fill_random();
    send_frame(1'b1, -1, 1'b1);
    wait_drain();
    chk("rebuild_err", bus.err, 0);
    check_ram();

`ifdef VJ_II_SQ_EN
    start_frame();
    for (int i = 0; i < N; i++) pix_arr[i] = 255;
    send_frame(1'b0, -1, 1'b1);
    wait_drain();
    chk("sq_ii19", sq_mem[19], 780300);
    chk("sat_ii19", mem[19], 3060);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
